// File: rtl/latency_report_pkg.sv
// Shared types, constants and helpers for the latency report transmitter.
// LATENCY_REPORT_ASCII_EN selects ASCII hex reports instead of raw bytes.
package latency_report_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

`ifdef LATENCY_REPORT_ASCII_EN
  localparam int CHARS_PER_BYTE = 2;
  localparam int TERM_LEN       = 2;
`else
  localparam int CHARS_PER_BYTE = 1;
  localparam int TERM_LEN       = 0;
`endif

  // Report length for a 32-bit meter.
  localparam int REPORT_LEN = 4 * CHARS_PER_BYTE + TERM_LEN;

  function automatic int report_len(input int lat_w);
    return (lat_w / 8) * CHARS_PER_BYTE + TERM_LEN;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/latency_report_tx.sv
// Captures the latency meter value on request and streams it MSB first.
// LATENCY_REPORT_ASCII_EN: uppercase hex chars plus CR LF; else raw bytes.
module latency_report_tx
  import latency_report_pkg::*;
#(
  parameter int LAT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [LAT_W-1:0] i_lat,
  output logic             o_get_ready,
  output logic [7:0]       o_byte,
  output logic             o_byte_valid,
  input  logic             i_byte_ready,
  output logic             o_busy
);

  localparam int LEN   = report_len(LAT_W);
  localparam int IDX_W = $clog2(LEN + 1);

  state_t           state;
  logic [LAT_W-1:0] cap;
  logic [IDX_W-1:0] idx;
  logic             hs;
  logic             last;

  function automatic logic [7:0] pick(
    input logic [LAT_W-1:0] v,
    input logic [IDX_W-1:0] i
  );
    logic [LAT_W-1:0] s;
`ifdef LATENCY_REPORT_ASCII_EN
    s = v << (32'(i) * 4);
    if (32'(i) < 2 * (LAT_W / 8))
      return nib2hex(s[LAT_W-1 -: 4]);
    else if (32'(i) == 2 * (LAT_W / 8))
      return ASCII_CR;
    else
      return ASCII_LF;
`else
    s = v << (32'(i) * 8);
    return s[LAT_W-1 -: 8];
`endif
  endfunction

  assign hs   = o_byte_valid && i_byte_ready;
  assign last = (idx == IDX_W'(LEN - 1));

  // o_byte is preloaded one step ahead so every output comes from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      cap          <= '0;
      idx          <= '0;
      o_get_ready  <= 1'b0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_get_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req) begin
            state        <= SEND;
            cap          <= i_lat;
            idx          <= '0;
            o_get_ready  <= 1'b1;
            o_byte       <= pick(i_lat, '0);
            o_byte_valid <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        SEND: begin
          if (hs) begin
            if (last) begin
              state        <= IDLE;
              idx          <= '0;
              o_byte       <= 8'h00;
              o_byte_valid <= 1'b0;
              o_busy       <= 1'b0;
            end else begin
              idx    <= idx + 1'b1;
              o_byte <= pick(cap, idx + 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
